// File: rtl/perf_counter_bank_if.sv
// Control, event and CSR read signals of the performance counter bank.
interface perf_counter_bank_if #(
  parameter int unsigned NCHAN = 8,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned INCW  = 2,
  parameter int unsigned AW    = 4
) ();
  logic                    start;
  logic                    busy;
  logic [NCHAN-1:0]        chan_en;
  logic [NCHAN*INCW-1:0]   ev_inc;
  logic                    snap;
  logic                    rd_en;
  logic [AW-1:0]           rd_addr;
  logic [WIDTH-1:0]        rd_data;
  logic                    rd_valid;
  logic [NCHAN:0]          overflow;

  modport master (
    output start, busy, chan_en, ev_inc, snap, rd_en, rd_addr,
    input  rd_data, rd_valid, overflow
  );

  modport slave (
    input  start, busy, chan_en, ev_inc, snap, rd_en, rd_addr,
    output rd_data, rd_valid, overflow
  );
endinterface

// File: rtl/perf_counter_bank.sv
// NCHAN event counters plus a busy-cycle counter, snapshot shadows and a 1-cycle CSR read port.
// Define PERFCNT_SATURATE_EN for saturating counters; otherwise counters wrap modulo 2^WIDTH.
module perf_counter_bank #(
  parameter int unsigned NCHAN = 8,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned INCW  = 2,
  parameter int unsigned AW    = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  perf_counter_bank_if.slave bus
);
  localparam int unsigned SW = WIDTH + 1;

  logic [WIDTH-1:0] cnt_q      [NCHAN];
  logic [WIDTH-1:0] cnt_d      [NCHAN];
  logic [WIDTH-1:0] shadow_q   [NCHAN];
  logic [WIDTH-1:0] cyc_q, cyc_d, shadow_cyc_q;
  logic [NCHAN:0]   ovf_q, ovf_d, shadow_ovf_q;
  logic [SW-1:0]    sum_c, cyc_sum_c;
  logic [WIDTH-1:0] rd_mux_c;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;

  // Next live values; the carry out of the widened sum is the overflow event
  always_comb begin
    ovf_d     = ovf_q;
    sum_c     = '0;
    cyc_sum_c = '0;
    cyc_d     = cyc_q;
    for (int i = 0; i < NCHAN; i++) begin
      cnt_d[i] = cnt_q[i];
      sum_c    = SW'(cnt_q[i]) + SW'(bus.ev_inc[i*INCW +: INCW]);
      if (bus.chan_en[i]) begin
`ifdef PERFCNT_SATURATE_EN
        cnt_d[i] = sum_c[WIDTH] ? {WIDTH{1'b1}} : sum_c[WIDTH-1:0];
`else
        cnt_d[i] = sum_c[WIDTH-1:0];
`endif
        ovf_d[i] = ovf_q[i] | sum_c[WIDTH];
      end
    end
    cyc_sum_c = SW'(cyc_q) + SW'(1);
    if (bus.busy) begin
`ifdef PERFCNT_SATURATE_EN
      cyc_d = cyc_sum_c[WIDTH] ? {WIDTH{1'b1}} : cyc_sum_c[WIDTH-1:0];
`else
      cyc_d = cyc_sum_c[WIDTH-1:0];
`endif
      ovf_d[NCHAN] = ovf_q[NCHAN] | cyc_sum_c[WIDTH];
    end
  end

  // Live counters; start wins over any increment in the same cycle
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NCHAN; i++) cnt_q[i] <= '0;
      cyc_q <= '0;
      ovf_q <= '0;
    end else if (bus.start) begin
      for (int i = 0; i < NCHAN; i++) cnt_q[i] <= '0;
      cyc_q <= '0;
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < NCHAN; i++) cnt_q[i] <= cnt_d[i];
      cyc_q <= cyc_d;
      ovf_q <= ovf_d;
    end
  end

  // Shadows capture pre-edge live values, so a colliding start is not seen
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NCHAN; i++) shadow_q[i] <= '0;
      shadow_cyc_q <= '0;
      shadow_ovf_q <= '0;
    end else if (bus.snap) begin
      for (int i = 0; i < NCHAN; i++) shadow_q[i] <= cnt_q[i];
      shadow_cyc_q <= cyc_q;
      shadow_ovf_q <= ovf_q;
    end
  end

  always_comb begin
    rd_mux_c = '0;
    for (int i = 0; i < NCHAN; i++) begin
      if (bus.rd_addr == AW'(i)) rd_mux_c = shadow_q[i];
    end
    if (bus.rd_addr == AW'(NCHAN))     rd_mux_c = shadow_cyc_q;
    if (bus.rd_addr == AW'(NCHAN + 1)) rd_mux_c = WIDTH'(shadow_ovf_q);
  end

  // Read port; rd_data holds between reads
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) rd_data_q <= rd_mux_c;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank in an 8-bit, 8-channel build; follows PERFCNT_SATURATE_EN.
module tb_perf_counter_bank;
  localparam int unsigned NCHAN = 8;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned INCW  = 2;
  localparam int unsigned AW    = 4;
`ifdef PERFCNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] exp;
  } rd_vec_t;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  int   checks = 0;
  int   errors = 0;
  rd_vec_t vec [11];

  perf_counter_bank_if #(.NCHAN(NCHAN), .WIDTH(WIDTH), .INCW(INCW), .AW(AW)) bus ();

  perf_counter_bank #(.NCHAN(NCHAN), .WIDTH(WIDTH), .INCW(INCW), .AW(AW)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One read request; back-to-back calls issue reads on consecutive cycles
  task automatic rd(input logic [AW-1:0] a, input logic [WIDTH-1:0] e, input string name);
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    tick();
    check({name, " valid"}, 32'(bus.rd_valid), 32'd1);
    check(name, 32'(bus.rd_data), 32'(e));
    bus.rd_en = 1'b0;
  endtask

  task automatic idle_read_check(input string name);
    tick();
    check({name, " valid low"}, 32'(bus.rd_valid), 32'd0);
  endtask

  task automatic do_snap();
    bus.snap = 1'b1;
    tick();
    bus.snap = 1'b0;
  endtask

  initial begin
    vec[0]  = '{4'd0,  8'd30};
    vec[1]  = '{4'd1,  8'd0};
    vec[2]  = '{4'd2,  8'd30};
    vec[3]  = '{4'd3,  8'd0};
    vec[4]  = '{4'd4,  8'd0};
    vec[5]  = '{4'd5,  8'd0};
    vec[6]  = '{4'd6,  8'd0};
    vec[7]  = '{4'd7,  8'd0};
    vec[8]  = '{4'd8,  8'd10};
    vec[9]  = '{4'd9,  8'd0};
    vec[10] = '{4'd15, 8'd0};

    sys_rst_n   = 1'b0;
    bus.start   = 1'b0;
    bus.busy    = 1'b0;
    bus.chan_en = '0;
    bus.ev_inc  = '0;
    bus.snap    = 1'b0;
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    check("reset rd_valid", 32'(bus.rd_valid), 32'd0);
    check("reset rd_data", 32'(bus.rd_data), 32'd0);
    check("reset overflow", 32'(bus.overflow), 32'd0);

    // Scenario 1: build some state, then reset mid-cycle and read everything back as zero
    bus.chan_en = 8'h01;
    bus.ev_inc  = 16'h0003;
    bus.busy    = 1'b1;
    repeat (3) tick();
    bus.busy   = 1'b0;
    bus.ev_inc = '0;
    do_snap();
    rd(4'd0, 8'd9, "pre-reset shadow ch0");
    #3 sys_rst_n = 1'b0;
    #1 check("async reset rd_data", 32'(bus.rd_data), 32'd0);
    #1 sys_rst_n = 1'b1;
    tick();
    do_snap();
    for (int a = 0; a <= int'(NCHAN) + 1; a++) rd(AW'(a), '0, "reset read");
    idle_read_check("reset read");

    // Scenario 2: masked multi-bit increments and busy cycles, checked from a vector table
    bus.chan_en = 8'b0000_0101;
    bus.ev_inc  = 16'hFFFF;
    bus.busy    = 1'b1;
    repeat (10) tick();
    bus.ev_inc = '0;
    bus.busy   = 1'b0;
    do_snap();
    for (int k = 0; k < 11; k++) rd(vec[k].addr, vec[k].exp, $sformatf("mask addr %0d", vec[k].addr));
    idle_read_check("mask");

    // Scenario 3: start, snap and an increment in the same cycle
    bus.ev_inc = 16'h0001;
    bus.busy   = 1'b1;
    bus.start  = 1'b1;
    bus.snap   = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.snap   = 1'b0;
    bus.busy   = 1'b0;
    bus.ev_inc = '0;
    rd(4'd0, 8'd30, "collide shadow ch0");
    rd(4'd2, 8'd30, "collide shadow ch2");
    rd(4'd8, 8'd10, "collide shadow cyc");
    do_snap();
    rd(4'd0, 8'd0, "post-start ch0");
    rd(4'd8, 8'd0, "post-start cyc");

    // Scenario 4/5: ch0 to 254, then +3 overflows; sticky flag, saturate or wrap
    bus.chan_en = 8'h01;
    bus.ev_inc  = 16'h0003;
    repeat (84) tick();
    bus.ev_inc = 16'h0002;
    tick();
    check("no overflow at 254", 32'(bus.overflow), 32'd0);
    bus.ev_inc = 16'h0003;
    tick();
    bus.ev_inc = '0;
    check("overflow set", 32'(bus.overflow), 32'h001);
    do_snap();
    rd(4'd0, SAT ? 8'd255 : 8'd1, "ovf ch0");
    rd(4'd9, 8'h01, "ovf flags read");
    bus.ev_inc = 16'h0003;
    tick();
    bus.ev_inc = '0;
    check("overflow sticky", 32'(bus.overflow), 32'h001);
    do_snap();
    rd(4'd0, SAT ? 8'd255 : 8'd4, "ovf ch0 after more");
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("start clears overflow", 32'(bus.overflow), 32'd0);
    do_snap();
    rd(4'd0, 8'd0, "start clears ch0");
    rd(4'd9, 8'd0, "start clears flags read");

    // Cycle counter overflow; disabled channels must hold despite increments
    bus.chan_en = '0;
    bus.ev_inc  = 16'hFFFF;
    bus.busy    = 1'b1;
    repeat (257) tick();
    bus.busy   = 1'b0;
    bus.ev_inc = '0;
    check("cycle overflow flag", 32'(bus.overflow), 32'h100);
    do_snap();
    rd(4'd8, SAT ? 8'd255 : 8'd1, "cycle counter ovf");
    rd(4'd0, 8'd0, "disabled ch0 hold");
    rd(4'd3, 8'd0, "disabled ch3 hold");

    // Scenario 6: back-to-back reads with a snap on the first
    bus.chan_en = 8'b0000_0011;
    bus.ev_inc  = 16'h0005;
    repeat (5) tick();
    bus.ev_inc = '0;
    bus.snap   = 1'b1;
    rd(4'd0, 8'd0, "b2b pre-snap ch0");
    bus.snap = 1'b0;
    rd(4'd1, 8'd5, "b2b new ch1");
    rd(4'd15, 8'd0, "b2b addr15");
    rd(4'd0, 8'd5, "b2b new ch0");
    idle_read_check("b2b");
    check("rd_data hold", 32'(bus.rd_data), 32'd5);
    check("overflow still sticky", 32'(bus.overflow), 32'h100);

    // Reset with a read pending: nothing survives
    bus.rd_en   = 1'b1;
    bus.rd_addr = 4'd0;
    #2 sys_rst_n = 1'b0;
    #1;
    check("midop reset overflow", 32'(bus.overflow), 32'd0);
    check("midop reset rd_data", 32'(bus.rd_data), 32'd0);
    tick();
    check("midop reset rd_valid", 32'(bus.rd_valid), 32'd0);
    sys_rst_n = 1'b1;
    bus.rd_en = 1'b0;
    tick();
    check("no read after reset", 32'(bus.rd_valid), 32'd0);
    do_snap();
    rd(4'd0, 8'd0, "after reset ch0");
    rd(4'd1, 8'd0, "after reset ch1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
